reorder_buffer: RTL

Parametrised in-order-commit reorder buffer for the out-of-order RISC-V core, sitting between the decoder (allocation), the execution units (writeback), and the register file, LSB and branch predictor (commit). It generalises the ROB to configurable depth and writeback-port count. It adds per-entry valid bits, a true occupancy counter, operand lookup with same-cycle writeback bypass, and a self-clearing mispredict path.

---
 rtl/rob_pkg.sv | 14 +
 rtl/rob_lookup.sv | 34 +++
 rtl/reorder_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared encodings and widths for the reorder buffer slice.
package rob_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ROB_REG   = 2'b00,
        ROB_STORE = 2'b01,
        ROB_BR    = 2'b10,
        ROB_RSVD  = 2'b11
    } rob_type_e;

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup: reads one ROB entry and lets a same-cycle writeback to
// that entry override it, highest-numbered port taking precedence.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned WB_PORTS = 2
) (
    input  logic [IDX_W-1:0]               q_idx,
    input  logic [DEPTH-1:0]               ent_valid,
    input  logic [DEPTH-1:0]               ent_ready,
    input  logic [DEPTH-1:0][XLEN-1:0]     ent_value,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]      wb_idx,
    input  logic [WB_PORTS*XLEN-1:0]       wb_value,
    output logic [XLEN-1:0]                q_value,
    output logic                           q_ready
);

    always_comb begin
        q_value = ent_value[q_idx];
        q_ready = ent_valid[q_idx] & ent_ready[q_idx];
        // Ascending scan so the last matching port is the one that sticks.
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && ent_valid[q_idx] &&
                (wb_idx[p*IDX_W +: IDX_W] == q_idx)) begin
                q_value = wb_value[p*XLEN +: XLEN];
                q_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: circular entry store with multi-port
// writeback, single-entry registered commit and a self-clearing mispredict.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned WB_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [IDX_W-1:0]          alloc_idx,
    input  logic [1:0]                alloc_type,
    input  logic [REG_W-1:0]          alloc_rd,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic                      alloc_pred_taken,
    input  logic                      alloc_done,
    input  logic [XLEN-1:0]           alloc_value,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_idx,
    input  logic [WB_PORTS*XLEN-1:0]  wb_value,
    input  logic [WB_PORTS-1:0]       wb_taken,
    input  logic [IDX_W-1:0]          q1_idx,
    input  logic [IDX_W-1:0]          q2_idx,
    output logic [XLEN-1:0]           q1_value,
    output logic [XLEN-1:0]           q2_value,
    output logic                      q1_ready,
    output logic                      q2_ready,
    output logic                      commit_reg_valid,
    output logic [REG_W-1:0]          commit_reg_rd,
    output logic [XLEN-1:0]           commit_reg_value,
    output logic [IDX_W-1:0]          commit_reg_idx,
    output logic                      commit_store_valid,
    output logic [IDX_W-1:0]          commit_store_idx,
    output logic                      commit_br_valid,
    output logic [XLEN-1:0]           commit_br_pc,
    output logic                      commit_br_taken,
    output logic                      mispredict_valid,
    output logic [XLEN-1:0]           mispredict_pc,
    output logic [IDX_W:0]            count
);

    logic [DEPTH-1:0]            valid_q, valid_d, ready_q, ready_d;
    logic [DEPTH-1:0]            pred_q, pred_d, taken_q, taken_d;
    logic [DEPTH-1:0][1:0]       type_q, type_d;
    logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0]  pc_q, pc_d, value_q, value_d;
    logic [IDX_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]              count_q, count_d;

    logic                        c_reg_valid_q, c_reg_valid_d;
    logic [REG_W-1:0]            c_reg_rd_q, c_reg_rd_d;
    logic [XLEN-1:0]             c_reg_value_q, c_reg_value_d;
    logic [IDX_W-1:0]            c_reg_idx_q, c_reg_idx_d;
    logic                        c_store_valid_q, c_store_valid_d;
    logic [IDX_W-1:0]            c_store_idx_q, c_store_idx_d;
    logic                        c_br_valid_q, c_br_valid_d;
    logic [XLEN-1:0]             c_br_pc_q, c_br_pc_d;
    logic                        c_br_taken_q, c_br_taken_d;
    logic                        mp_valid_q, mp_valid_d;
    logic [XLEN-1:0]             mp_pc_q, mp_pc_d;

    logic                        do_commit, do_alloc, do_clear;

    // Registered occupancy only, so a same-cycle commit never frees a slot.
    assign alloc_ready = (count_q < (IDX_W+1)'(DEPTH));
    assign alloc_idx   = tail_q;
    assign count       = count_q;

    always_comb begin
        valid_d = valid_q;  ready_d = ready_q;  pred_d  = pred_q;
        taken_d = taken_q;  type_d  = type_q;   rd_d    = rd_q;
        pc_d    = pc_q;     value_d = value_q;
        head_d  = head_q;   tail_d  = tail_q;   count_d = count_q;
        c_reg_valid_d   = c_reg_valid_q;   c_reg_rd_d    = c_reg_rd_q;
        c_reg_value_d   = c_reg_value_q;   c_reg_idx_d   = c_reg_idx_q;
        c_store_valid_d = c_store_valid_q; c_store_idx_d = c_store_idx_q;
        c_br_valid_d    = c_br_valid_q;    c_br_pc_d     = c_br_pc_q;
        c_br_taken_d    = c_br_taken_q;
        mp_valid_d      = mp_valid_q;      mp_pc_d       = mp_pc_q;
        do_commit = 1'b0;
        do_alloc  = 1'b0;
        do_clear  = 1'b0;

        if (rdy) begin
            c_reg_valid_d   = 1'b0;
            c_store_valid_d = 1'b0;
            c_br_valid_d    = 1'b0;
            mp_valid_d      = 1'b0;

            if (flush) begin
                do_clear = 1'b1;
            end else begin
                do_commit = (count_q != '0) && valid_q[head_q] && ready_q[head_q];
                do_alloc  = alloc_valid && alloc_ready;

                for (int unsigned p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && valid_q[wb_idx[p*IDX_W +: IDX_W]]) begin
                        ready_d[wb_idx[p*IDX_W +: IDX_W]] = 1'b1;
                        value_d[wb_idx[p*IDX_W +: IDX_W]] = wb_value[p*XLEN +: XLEN];
                        taken_d[wb_idx[p*IDX_W +: IDX_W]] = wb_taken[p];
                    end
                end

                if (do_commit) begin
                    case (type_q[head_q])
                        ROB_STORE: begin
                            c_store_valid_d = 1'b1;
                            c_store_idx_d   = head_q;
                        end
                        ROB_BR: begin
                            c_br_valid_d = 1'b1;
                            c_br_pc_d    = pc_q[head_q];
                            c_br_taken_d = taken_q[head_q];
                            if (pred_q[head_q] != taken_q[head_q]) begin
                                mp_valid_d = 1'b1;
                                mp_pc_d    = value_q[head_q];
                                do_clear   = 1'b1;
                            end
                        end
                        default: begin
                            c_reg_valid_d = 1'b1;
                            c_reg_rd_d    = rd_q[head_q];
                            c_reg_value_d = value_q[head_q];
                            c_reg_idx_d   = head_q;
                        end
                    endcase
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + IDX_W'(1);
                end

                if (do_alloc) begin
                    valid_d[tail_q] = 1'b1;
                    ready_d[tail_q] = alloc_done;
                    pred_d[tail_q]  = alloc_pred_taken;
                    taken_d[tail_q] = alloc_pred_taken;
                    pc_d[tail_q]    = alloc_pc;
                    value_d[tail_q] = alloc_value;
                    // Reserved type is stored as a reg-write to x0.
                    type_d[tail_q]  = (alloc_type == ROB_RSVD) ? 2'(ROB_REG) : alloc_type;
                    rd_d[tail_q]    = (alloc_type == ROB_RSVD) ? '0 : alloc_rd;
                    tail_d          = tail_q + IDX_W'(1);
                end

                count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
            end

            if (do_clear) begin
                valid_d = '0;
                ready_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;  ready_q <= '0;  pred_q  <= '0;  taken_q <= '0;
            type_q  <= '0;  rd_q    <= '0;  pc_q    <= '0;  value_q <= '0;
            head_q  <= '0;  tail_q  <= '0;  count_q <= '0;
            c_reg_valid_q   <= 1'b0; c_reg_rd_q    <= '0;
            c_reg_value_q   <= '0;   c_reg_idx_q   <= '0;
            c_store_valid_q <= 1'b0; c_store_idx_q <= '0;
            c_br_valid_q    <= 1'b0; c_br_pc_q     <= '0;
            c_br_taken_q    <= 1'b0;
            mp_valid_q      <= 1'b0; mp_pc_q       <= '0;
        end else begin
            valid_q <= valid_d;  ready_q <= ready_d;  pred_q  <= pred_d;
            taken_q <= taken_d;  type_q  <= type_d;   rd_q    <= rd_d;
            pc_q    <= pc_d;     value_q <= value_d;
            head_q  <= head_d;   tail_q  <= tail_d;   count_q <= count_d;
            c_reg_valid_q   <= c_reg_valid_d;   c_reg_rd_q    <= c_reg_rd_d;
            c_reg_value_q   <= c_reg_value_d;   c_reg_idx_q   <= c_reg_idx_d;
            c_store_valid_q <= c_store_valid_d; c_store_idx_q <= c_store_idx_d;
            c_br_valid_q    <= c_br_valid_d;    c_br_pc_q     <= c_br_pc_d;
            c_br_taken_q    <= c_br_taken_d;
            mp_valid_q      <= mp_valid_d;      mp_pc_q       <= mp_pc_d;
        end
    end

    assign commit_reg_valid   = c_reg_valid_q;
    assign commit_reg_rd      = c_reg_rd_q;
    assign commit_reg_value   = c_reg_value_q;
    assign commit_reg_idx     = c_reg_idx_q;
    assign commit_store_valid = c_store_valid_q;
    assign commit_store_idx   = c_store_idx_q;
    assign commit_br_valid    = c_br_valid_q;
    assign commit_br_pc       = c_br_pc_q;
    assign commit_br_taken    = c_br_taken_q;
    assign mispredict_valid   = mp_valid_q;
    assign mispredict_pc      = mp_pc_q;

    rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS)) u_lookup_q1 (
        .q_idx     (q1_idx),
        .ent_valid (valid_q),
        .ent_ready (ready_q),
        .ent_value (value_q),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .wb_value  (wb_value),
        .q_value   (q1_value),
        .q_ready   (q1_ready)
    );

    rob_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS)) u_lookup_q2 (
        .q_idx     (q2_idx),
        .ent_valid (valid_q),
        .ent_ready (ready_q),
        .ent_value (value_q),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .wb_value  (wb_value),
        .q_value   (q2_value),
        .q_ready   (q2_ready)
    );

endmodule
